// File: rtl/rc_ack_arbiter.sv
// rc_ack_arbiter: round-robin arbiter that returns an active-low ack to one of
// NUM_CH active-low requesters once the shared resource reports idle.
// Ack can be a one-cycle pulse or held until release (four-phase).
// A request that waits too long for the resource is aborted by a timeout.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   rc_reqn      per-channel request, active low
//   rc_is_idle   shared resource idle, active high
//   rc_ackn      per-channel ack, active low, registered
//   rc_grant_id  index of the granted channel, registered
//   rc_busy      high whenever the arbiter is not in IDLE, registered
//   rc_timeout   one-cycle pulse when a wait is aborted by the timeout
module rc_ack_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter bit          FOUR_PHASE = 1'b1,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8,
  localparam int unsigned GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] rc_reqn,
  input  logic              rc_is_idle,
  output logic [NUM_CH-1:0] rc_ackn,
  output logic [GW-1:0]     rc_grant_id,
  output logic              rc_busy,
  output logic              rc_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  // Last counter value before the abort; unused when TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  // Pointer starts at the top channel so channel 0 is served first.
  localparam logic [GW-1:0]   PTR_RST = GW'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gid_q, gid_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ackn_q, ackn_d;
  logic                busy_q, busy_d;
  logic                to_q, to_d;

  logic                pick_found;
  logic [GW-1:0]       pick_id;
  logic [GW-1:0]       cand;

  assign rc_ackn     = ackn_q;
  assign rc_grant_id = gid_q;
  assign rc_busy     = busy_q;
  assign rc_timeout  = to_q;

  // Round-robin search: first low request starting just above the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = GW'((32'(ptr_q) + i) % NUM_CH);
      if (!pick_found && !rc_reqn[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    ackn_d  = '1;
    to_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gid_d   = pick_id;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (rc_reqn[gid_q]) begin
          // Requester withdrew: drop it without touching the pointer.
          state_d = ST_IDLE;
        end else if (rc_is_idle) begin
          state_d = ST_ACK;
          ackn_d  = ~(NUM_CH'(1) << gid_q);
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          // Timed-out channel loses its turn.
          state_d = ST_IDLE;
          to_d    = 1'b1;
          ptr_d   = gid_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      ST_ACK: begin
        ptr_d = gid_q;
        if (FOUR_PHASE) begin
          if (rc_reqn[gid_q]) begin
            state_d = ST_REL;
          end else begin
            ackn_d = ackn_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REL: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      gid_q   <= '0;
      cnt_q   <= '0;
      ackn_q  <= '1;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      ackn_q  <= ackn_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

endmodule
